// File: rtl/rom_burst.sv
// Parametrised synchronous lookup ROM with optional output register,
// valid/ready handshake and wrap-around burst reads.
module rom_burst #(
    parameter int              DATA_W     = 4,
    parameter int              ADDR_W     = 4,
    parameter int              DEPTH      = 16,
    parameter int              INIT_COUNT = 3,
    parameter logic [DATA_W-1:0] FILL     = '0,
    parameter int              BURST_LEN  = 4,
    parameter int              OUT_REG    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd,
    input  logic              burst,
    input  logic [ADDR_W-1:0] address,
    output logic              ready,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              done
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                iss;
    logic                iss_last;
    logic [ADDR_W-1:0]   iss_addr;
    logic                p1_v_q, p1_last_q;
    logic [DATA_W-1:0]   p1_d_q;

    function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
        if (int'(a) < DEPTH && int'(a) < INIT_COUNT)
            return DATA_W'(a);
        return FILL;
    endfunction

    // Wrap to entry 0 from the last entry or from any out-of-range address
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        if (int'(a) >= DEPTH - 1)
            return '0;
        return a + ADDR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (rd && burst && (BURST_LEN > 1)) begin
                    state_d = BURST;
                    addr_d  = next_addr(address);
                    cnt_d   = CNT_W'(BURST_LEN - 1);
                end
            end
            BURST: begin
                addr_d = next_addr(addr_q);
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1))
                    state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ready    = (state_q == IDLE);
        iss      = 1'b0;
        iss_addr = address;
        iss_last = 1'b1;
        unique case (state_q)
            IDLE: begin
                iss      = rd;
                iss_last = !burst || (BURST_LEN == 1);
            end
            BURST: begin
                iss      = 1'b1;
                iss_addr = addr_q;
                iss_last = (cnt_q == CNT_W'(1));
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p1_v_q    <= 1'b0;
            p1_last_q <= 1'b0;
            p1_d_q    <= '0;
        end else begin
            p1_v_q    <= iss;
            p1_last_q <= iss && iss_last;
            if (iss)
                p1_d_q <= rom_f(iss_addr);
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic              p2_v_q, p2_last_q;
            logic [DATA_W-1:0] p2_d_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    p2_v_q    <= 1'b0;
                    p2_last_q <= 1'b0;
                    p2_d_q    <= '0;
                end else begin
                    p2_v_q    <= p1_v_q;
                    p2_last_q <= p1_last_q;
                    if (p1_v_q)
                        p2_d_q <= p1_d_q;
                end
            end

            assign out       = p2_d_q;
            assign out_valid = p2_v_q;
            assign done      = p2_last_q;
        end else begin : g_direct
            assign out       = p1_d_q;
            assign out_valid = p1_v_q;
            assign done      = p1_last_q;
        end
    endgenerate

endmodule

// File: tb/tb_rom_burst.sv
// Randomised scoreboard bench for rom_burst: two configurations
// (registered output with bursts, single-stage with BURST_LEN=1).
module tb_rom_burst;

    localparam int A_DW = 4, A_DEP = 12, A_INIT = 10, A_FILL = 10;
    localparam int A_BL = 4, A_OR = 1;
    localparam int B_DW = 3, B_DEP = 14, B_INIT = 11, B_FILL = 5;
    localparam int B_BL = 1, B_OR = 0;

    typedef struct {
        int   d;
        int   c;
        logic l;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rd_i    [2];
    logic       burst_i [2];
    logic [3:0] addr_i  [2];
    logic       ready_w [2];
    logic       ov_w    [2];
    logic       done_w  [2];
    logic [3:0] outv    [2];
    logic       ready_a, ready_b, ov_a, ov_b, done_a, done_b;
    logic [3:0] out_a;
    logic [2:0] out_b;

    int   cyc = 0;
    logic rst_seen = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   blocked [2];
    int   last_out [2];
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    rom_burst #(
        .DATA_W(A_DW), .ADDR_W(4), .DEPTH(A_DEP), .INIT_COUNT(A_INIT),
        .FILL(4'(A_FILL)), .BURST_LEN(A_BL), .OUT_REG(A_OR)
    ) u_a (
        .clk(clk), .rst(rst), .rd(rd_i[0]), .burst(burst_i[0]),
        .address(addr_i[0]), .ready(ready_a), .out(out_a),
        .out_valid(ov_a), .done(done_a)
    );

    rom_burst #(
        .DATA_W(B_DW), .ADDR_W(4), .DEPTH(B_DEP), .INIT_COUNT(B_INIT),
        .FILL(3'(B_FILL)), .BURST_LEN(B_BL), .OUT_REG(B_OR)
    ) u_b (
        .clk(clk), .rst(rst), .rd(rd_i[1]), .burst(burst_i[1]),
        .address(addr_i[1]), .ready(ready_b), .out(out_b),
        .out_valid(ov_b), .done(done_b)
    );

    assign ready_w[0] = ready_a;
    assign ready_w[1] = ready_b;
    assign ov_w[0]    = ov_a;
    assign ov_w[1]    = ov_b;
    assign done_w[0]  = done_a;
    assign done_w[1]  = done_b;
    assign outv[0]    = out_a;
    assign outv[1]    = {1'b0, out_b};

    task automatic chk(input string name, input int k, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d: got %0d want %0d",
                     name, k, cyc, act, exp);
        end
    endtask

    // Reference contents straight from the table rules
    function automatic int ref_val(input int k, input int a);
        int dep  = (k == 0) ? A_DEP : B_DEP;
        int init = (k == 0) ? A_INIT : B_INIT;
        int dw   = (k == 0) ? A_DW : B_DW;
        int fill = (k == 0) ? A_FILL : B_FILL;
        if (a < dep && a < init)
            return a % (1 << dw);
        return fill;
    endfunction

    function automatic int nxt(input int k, input int a);
        int dep = (k == 0) ? A_DEP : B_DEP;
        return (a >= dep - 1) ? 0 : a + 1;
    endfunction

    task automatic accept(input int k, input int a, input int n, input int p);
        int   cur = a;
        int   lat = (k == 0) ? 1 + A_OR : 1 + B_OR;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.d = ref_val(k, cur);
            e.c = p + i + lat - 1;
            e.l = (i == n - 1);
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
            cur = nxt(k, cur);
        end
        if (n > 1)
            blocked[k] = p + n - 1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cyc == 0)
                continue;
            for (int k = 0; k < 2; k++) begin
                if (rst_seen) begin
                    chk("rst_out", k, int'(outv[k]), 0);
                    chk("rst_valid", k, int'(ov_w[k]), 0);
                    chk("rst_done", k, int'(done_w[k]), 0);
                    chk("rst_ready", k, int'(ready_w[k]), 1);
                    last_out[k] = 0;
                end else if (ov_w[k]) begin
                    if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                        chk("unexpected_beat", k, 1, 0);
                    end else begin
                        e = (k == 0) ? q0.pop_front() : q1.pop_front();
                        chk("data", k, int'(outv[k]), e.d);
                        chk("beat_cycle", k, cyc, e.c);
                        chk("done", k, int'(done_w[k]), int'(e.l));
                    end
                    last_out[k] = int'(outv[k]);
                end else begin
                    chk("idle_done", k, int'(done_w[k]), 0);
                    chk("hold", k, int'(outv[k]), last_out[k]);
                end
            end
        end
    end

    initial begin
        int n_beats;
        for (int k = 0; k < 2; k++) begin
            rd_i[k]     = 1'b0;
            burst_i[k]  = 1'b0;
            addr_i[k]   = '0;
            blocked[k]  = 0;
            last_out[k] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            #1;
            rst = (n >= 150 && n < 152) || (n >= 400 && n < 402);
            if (rst) begin
                for (int k = 0; k < 2; k++) begin
                    rd_i[k]    = 1'b0;
                    blocked[k] = 0;
                end
                q0.delete();
                q1.delete();
                continue;
            end
            for (int k = 0; k < 2; k++) begin
                chk("ready", k, int'(ready_w[k]), int'(cyc >= blocked[k]));
                rd_i[k]    = ($urandom_range(0, 3) != 0);
                burst_i[k] = ($urandom_range(0, 1) != 0);
                addr_i[k]  = 4'($urandom_range(0, 15));
                if (n == 0) begin
                    rd_i[k]    = 1'b1;
                    burst_i[k] = 1'b1;
                    addr_i[k]  = (k == 0) ? 4'd13 : 4'd2;
                end
                if (rd_i[k] && cyc >= blocked[k]) begin
                    n_beats = burst_i[k] ? ((k == 0) ? A_BL : B_BL) : 1;
                    accept(k, int'(addr_i[k]), n_beats, cyc + 1);
                end
            end
        end
        @(negedge clk);
        #1;
        rd_i[0] = 1'b0;
        rd_i[1] = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        chk("drain", 0, q0.size(), 0);
        chk("drain", 1, q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
